gerenciador_caminho: RTL and testbench
======================================

# gerenciador_caminho

Path-reconstruction engine for the shortest-path accelerator: stores the predecessor ("anterior") of every settled node as the neighbour-locator writes it, then on command walks from destination back to source and streams the path source→destination over a valid/ready interface. Parametrised successor of the fixed 6-bit predecessor manager. Adds node-count/path-depth generalisation, per-node valid tracking, loop and unreachable detection, and a back-pressured output stream. Sits between the neighbour-locator write port and the external path consumer, triggered by the state-machine controller's build-path strobe.

## Interface
- ADDR_WIDTH, 6, node address width
- NUM_NODES, 2**ADDR_WIDTH, predecessor memory depth
- MAX_CAMINHO, NUM_NODES, maximum path length in nodes (stack depth)
- LEN_WIDTH, $clog2(MAX_CAMINHO+1), path-length counter width
- Clock and reset: reset rst_n, asynchronous, active-low; clock clk.
- clk  in  1  clock
- rst_n  in  1  async active-low reset
- limpar_in  in  1  pulse; clears all per-node valid bits (new search)
- wr_en_in  in  1  predecessor write strobe
- wr_addr_in  in  ADDR_WIDTH  node being settled
- wr_data_in  in  ADDR_WIDTH  its predecessor
- construir_in  in  1  pulse; start reconstruction
- fonte_in  in  ADDR_WIDTH  source node, sampled with construir_in
- destino_in  in  ADDR_WIDTH  destination node, sampled with construir_in
- ocupado_out  out  1  high in any state except OCIOSO
- caminho_valid_out  out  1  output beat valid
- caminho_ready_in  in  1  consumer accepts beat
- caminho_addr_out  out  ADDR_WIDTH  path node
- caminho_ultimo_out  out  1  beat is destination (last)
- caminho_tamanho_out  out  LEN_WIDTH  path length in nodes, valid while EMITE
- concluido_out  out  1  one-cycle pulse when reconstruction ends (success or error)
- erro_out  out  1  one-cycle pulse with concluido_out on failure

## Operation
- Storage: predecessor RAM NUM_NODES×ADDR_WIDTH with synchronous read (1-cycle). Valid vector NUM_NODES bits. Path stack MAX_CAMINHO×ADDR_WIDTH with pointer sp (LEN_WIDTH).
- Write: in OCIOSO, wr_en_in writes RAM[wr_addr_in] and sets valid[wr_addr_in]. Writes outside OCIOSO are dropped. limpar_in in OCIOSO clears the valid vector. If limpar_in and wr_en_in coincide, the write's valid bit wins.
- FSM states: OCIOSO, BUSCA, AVALIA, EMITE.
- OCIOSO: on construir_in, latch fonte/destino, set cur=destino, sp=0, go to BUSCA. construir_in outside OCIOSO is ignored.
- BUSCA: push cur (stack[sp]=cur, sp++). Then:
  - If cur==fonte, go to EMITE.
  - Else if sp (after increment) == MAX_CAMINHO, or valid[cur]==0, pulse erro_out+concluido_out and go to OCIOSO.
  - Else issue RAM read at cur and go to AVALIA.
- AVALIA: cur = read data; go to BUSCA.
- EMITE: caminho_tamanho_out = sp. Pop from stack top (stack[sp-1] = fonte first). Output register holds beat with valid=1. On valid&&ready: sp--, load next beat. The beat with sp==1 carries ultimo=1. After the ultimo beat is accepted, pulse concluido_out and go to OCIOSO.
- fonte==destino: one beat, ultimo=1, tamanho=1, no RAM read.
- Width rules: sp never exceeds MAX_CAMINHO. No wrap.

## Timing
- Reset values: all outputs 0, state OCIOSO, valid vector 0, sp=0, cur=0. RAM contents undefined and unused until written.
- Walk costs 2 cycles per non-source node plus 1 for the source. A path of L nodes enters EMITE 2L-1 cycles after construir_in.
- First beat is valid 1 cycle after entering EMITE (registered output). Sustained 1 beat/cycle while ready is held high.
- caminho_addr_out and caminho_ultimo_out stay stable while valid&&!ready.
- concluido_out pulses in the cycle after the last handshake. On error it pulses in the cycle after the failing BUSCA.
- Reset mid-operation: immediate return to OCIOSO, output valid dropped, valid vector cleared.

## Structure
- Shared package (caminho_pkg): state encoding localparams, LEN_WIDTH derivation function.
- Sub-module: pilha_caminho (parametrised LIFO: push, pop, sp, top read, registered output stage). FSM and predecessor RAM stay in gerenciador_caminho.

## Test plan
- Write pred[5]=3, pred[3]=0. construir fonte=0, destino=5, ready=1 → beats 0,3,5. Last beat has ultimo=1. tamanho=3. concluido pulses; erro stays 0.
- fonte=destino=9 → single beat 9, ultimo=1, tamanho=1, first beat 2 cycles after construir.
- Same path as the first test with ready toggling 1,0,0,1,… → each beat is held stable while ready=0. No beats are lost or duplicated.
- limpar, then write pred[7]=4 only; construir fonte=0, destino=7 → erro_out and concluido_out pulse together, zero beats, returns to OCIOSO.
- MAX_CAMINHO=4, loop pred[1]=2, pred[2]=1; fonte=0, destino=1 → erro after 4 pushes. Writes issued during the walk do not change RAM.
- Assert rst_n low mid-EMITE → caminho_valid_out=0 next cycle. A subsequent construir without re-written preds gives erro (valid vector cleared).

Source files
------------

// File: rtl/caminho_pkg.sv
// Shared types and width helpers for the path-reconstruction engine.
package caminho_pkg;

    typedef enum logic [1:0] {
        OCIOSO,
        BUSCA,
        AVALIA,
        EMITE
    } estado_t;

    function automatic int unsigned largura_len(input int unsigned max_caminho);
        return $clog2(max_caminho + 1);
    endfunction

    function automatic int unsigned largura_idx(input int unsigned profundidade);
        return (profundidade > 1) ? $clog2(profundidade) : 1;
    endfunction

endpackage

// File: rtl/pilha_caminho.sv
// Path LIFO with a registered valid/ready output stage; pops on each accepted beat,
// flags the beat that empties the stack as the last one.
module pilha_caminho
    import caminho_pkg::*;
#(
    parameter int unsigned DATA_WIDTH   = 6,
    parameter int unsigned PROFUNDIDADE = 64,
    parameter int unsigned LEN_WIDTH    = largura_len(PROFUNDIDADE)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  limpar_in,
    input  logic                  push_in,
    input  logic [DATA_WIDTH-1:0] push_dado_in,
    input  logic                  emitir_in,
    input  logic                  pronto_in,
    output logic [LEN_WIDTH-1:0]  sp_out,
    output logic                  saida_valid_out,
    output logic [DATA_WIDTH-1:0] saida_dado_out,
    output logic                  saida_ultimo_out,
    output logic                  fim_out
);

    localparam int unsigned IDX_W = largura_idx(PROFUNDIDADE);
    localparam logic [LEN_WIDTH-1:0] UM   = LEN_WIDTH'(1);
    localparam logic [LEN_WIDTH-1:0] DOIS = LEN_WIDTH'(2);

    logic [DATA_WIDTH-1:0] mem [PROFUNDIDADE];
    logic [LEN_WIDTH-1:0]  sp_q, sp_d;
    logic                  valid_q, valid_d;
    logic                  ultimo_q, ultimo_d;
    logic [DATA_WIDTH-1:0] dado_q, dado_d;
    logic [IDX_W-1:0]      idx_push, idx_topo, idx_prox;

    assign idx_push = IDX_W'(sp_q);
    assign idx_topo = IDX_W'(sp_q - UM);
    assign idx_prox = IDX_W'(sp_q - DOIS);
    assign fim_out  = emitir_in && valid_q && pronto_in && ultimo_q;

    always_comb begin
        sp_d     = sp_q;
        valid_d  = valid_q;
        ultimo_d = ultimo_q;
        dado_d   = dado_q;
        if (limpar_in) begin
            sp_d     = '0;
            valid_d  = 1'b0;
            ultimo_d = 1'b0;
            dado_d   = '0;
        end else if (push_in) begin
            sp_d = sp_q + UM;
        end else if (emitir_in) begin
            if (!valid_q) begin
                if (sp_q != '0) begin
                    valid_d  = 1'b1;
                    dado_d   = mem[idx_topo];
                    ultimo_d = (sp_q == UM);
                end
            end else if (pronto_in) begin
                // Popping now exposes the entry below the current top.
                sp_d = sp_q - UM;
                if (ultimo_q) begin
                    valid_d  = 1'b0;
                    ultimo_d = 1'b0;
                end else begin
                    dado_d   = mem[idx_prox];
                    ultimo_d = (sp_q == DOIS);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sp_q     <= '0;
            valid_q  <= 1'b0;
            ultimo_q <= 1'b0;
            dado_q   <= '0;
        end else begin
            sp_q     <= sp_d;
            valid_q  <= valid_d;
            ultimo_q <= ultimo_d;
            dado_q   <= dado_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_in && !limpar_in) mem[idx_push] <= push_dado_in;
    end

    assign sp_out           = sp_q;
    assign saida_valid_out  = valid_q;
    assign saida_dado_out   = dado_q;
    assign saida_ultimo_out = ultimo_q;

endmodule

// File: rtl/gerenciador_caminho.sv
// Predecessor store and path walker: records settled-node predecessors, walks
// destination back to source on request and streams the path source-first.
module gerenciador_caminho
    import caminho_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH  = 6,
    parameter int unsigned NUM_NODES   = 2**ADDR_WIDTH,
    parameter int unsigned MAX_CAMINHO = NUM_NODES,
    parameter int unsigned LEN_WIDTH   = largura_len(MAX_CAMINHO)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  limpar_in,
    input  logic                  wr_en_in,
    input  logic [ADDR_WIDTH-1:0] wr_addr_in,
    input  logic [ADDR_WIDTH-1:0] wr_data_in,
    input  logic                  construir_in,
    input  logic [ADDR_WIDTH-1:0] fonte_in,
    input  logic [ADDR_WIDTH-1:0] destino_in,
    output logic                  ocupado_out,
    output logic                  caminho_valid_out,
    input  logic                  caminho_ready_in,
    output logic [ADDR_WIDTH-1:0] caminho_addr_out,
    output logic                  caminho_ultimo_out,
    output logic [LEN_WIDTH-1:0]  caminho_tamanho_out,
    output logic                  concluido_out,
    output logic                  erro_out
);

    localparam logic [LEN_WIDTH-1:0] UM      = LEN_WIDTH'(1);
    localparam logic [LEN_WIDTH-1:0] MAX_LEN = LEN_WIDTH'(MAX_CAMINHO);

    estado_t               estado_q, estado_d;
    logic [ADDR_WIDTH-1:0] cur_q, cur_d;
    logic [ADDR_WIDTH-1:0] fonte_q, fonte_d;
    logic [LEN_WIDTH-1:0]  tam_q, tam_d;
    logic                  concl_q, concl_d;
    logic                  erro_q, erro_d;
    logic [NUM_NODES-1:0]  valido_q, valido_d;

    logic [ADDR_WIDTH-1:0] pred_mem [NUM_NODES];
    logic [ADDR_WIDTH-1:0] pred_rd;
    logic                  ler, push, limpar_pilha, emitir, fim;
    logic [LEN_WIDTH-1:0]  sp, sp_apos;

    assign sp_apos = sp + UM;

    always_comb begin
        estado_d     = estado_q;
        cur_d        = cur_q;
        fonte_d      = fonte_q;
        tam_d        = tam_q;
        concl_d      = 1'b0;
        erro_d       = 1'b0;
        valido_d     = valido_q;
        ler          = 1'b0;
        push         = 1'b0;
        limpar_pilha = 1'b0;
        emitir       = 1'b0;
        case (estado_q)
            OCIOSO: begin
                // Clear first so a coincident write keeps its valid bit.
                if (limpar_in) valido_d = '0;
                if (wr_en_in) valido_d[wr_addr_in] = 1'b1;
                if (construir_in) begin
                    fonte_d      = fonte_in;
                    cur_d        = destino_in;
                    limpar_pilha = 1'b1;
                    estado_d     = BUSCA;
                end
            end
            BUSCA: begin
                push = 1'b1;
                if (cur_q == fonte_q) begin
                    tam_d    = sp_apos;
                    estado_d = EMITE;
                end else if (sp_apos == MAX_LEN || !valido_q[cur_q]) begin
                    erro_d   = 1'b1;
                    concl_d  = 1'b1;
                    estado_d = OCIOSO;
                end else begin
                    ler      = 1'b1;
                    estado_d = AVALIA;
                end
            end
            AVALIA: begin
                cur_d    = pred_rd;
                estado_d = BUSCA;
            end
            EMITE: begin
                emitir = 1'b1;
                if (fim) begin
                    concl_d  = 1'b1;
                    tam_d    = '0;
                    estado_d = OCIOSO;
                end
            end
            default: estado_d = OCIOSO;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado_q <= OCIOSO;
            cur_q    <= '0;
            fonte_q  <= '0;
            tam_q    <= '0;
            concl_q  <= 1'b0;
            erro_q   <= 1'b0;
            valido_q <= '0;
        end else begin
            estado_q <= estado_d;
            cur_q    <= cur_d;
            fonte_q  <= fonte_d;
            tam_q    <= tam_d;
            concl_q  <= concl_d;
            erro_q   <= erro_d;
            valido_q <= valido_d;
        end
    end

    always_ff @(posedge clk) begin
        if (estado_q == OCIOSO && wr_en_in) pred_mem[wr_addr_in] <= wr_data_in;
        if (ler) pred_rd <= pred_mem[cur_q];
    end

    pilha_caminho #(
        .DATA_WIDTH  (ADDR_WIDTH),
        .PROFUNDIDADE(MAX_CAMINHO),
        .LEN_WIDTH   (LEN_WIDTH)
    ) u_pilha (
        .clk             (clk),
        .rst_n           (rst_n),
        .limpar_in       (limpar_pilha),
        .push_in         (push),
        .push_dado_in    (cur_q),
        .emitir_in       (emitir),
        .pronto_in       (caminho_ready_in),
        .sp_out          (sp),
        .saida_valid_out (caminho_valid_out),
        .saida_dado_out  (caminho_addr_out),
        .saida_ultimo_out(caminho_ultimo_out),
        .fim_out         (fim)
    );

    assign ocupado_out         = (estado_q != OCIOSO);
    assign caminho_tamanho_out = tam_q;
    assign concluido_out       = concl_q;
    assign erro_out            = erro_q;

endmodule

// File: tb/tb_gerenciador_caminho.sv
// Directed bench for gerenciador_caminho: default instance plus a MAX_CAMINHO=4
// instance sharing the same stimulus, used for the loop/stack-depth case.
module tb_gerenciador_caminho;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       limpar, wr_en, construir, ready;
    logic [5:0] wr_addr, wr_data, fonte, destino;

    logic       ocupado, cv, cu, concl, erro;
    logic [5:0] ca;
    logic [6:0] ct;
    logic       d4_ocupado, d4_cv, d4_cu, d4_concl, d4_erro;
    logic [5:0] d4_ca;
    logic [2:0] d4_ct;

    int n_cmp = 0;
    int n_err = 0;

    localparam logic       RDY_SEQ [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    localparam logic [5:0] EXP_A   [6] = '{6'd3, 6'd3, 6'd3, 6'd5, 6'd5, 6'd5};
    localparam logic       EXP_U   [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};

    gerenciador_caminho dut (
        .clk(clk), .rst_n(rst_n), .limpar_in(limpar), .wr_en_in(wr_en),
        .wr_addr_in(wr_addr), .wr_data_in(wr_data), .construir_in(construir),
        .fonte_in(fonte), .destino_in(destino), .ocupado_out(ocupado),
        .caminho_valid_out(cv), .caminho_ready_in(ready), .caminho_addr_out(ca),
        .caminho_ultimo_out(cu), .caminho_tamanho_out(ct),
        .concluido_out(concl), .erro_out(erro)
    );

    gerenciador_caminho #(.ADDR_WIDTH(6), .MAX_CAMINHO(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .limpar_in(limpar), .wr_en_in(wr_en),
        .wr_addr_in(wr_addr), .wr_data_in(wr_data), .construir_in(construir),
        .fonte_in(fonte), .destino_in(destino), .ocupado_out(d4_ocupado),
        .caminho_valid_out(d4_cv), .caminho_ready_in(ready), .caminho_addr_out(d4_ca),
        .caminho_ultimo_out(d4_cu), .caminho_tamanho_out(d4_ct),
        .concluido_out(d4_concl), .erro_out(d4_erro)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout, expected $finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic tickn(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_beat(input string tag, input logic v, input logic [5:0] a, input logic u);
        chk({tag, ".valid"}, cv, v);
        if (v) begin
            chk({tag, ".addr"}, ca, a);
            chk({tag, ".ultimo"}, cu, u);
        end
    endtask

    task automatic write_pred(input logic [5:0] a, input logic [5:0] d);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic start(input logic [5:0] f, input logic [5:0] d);
        fonte = f; destino = d; construir = 1'b1;
        tick();
        construir = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; limpar = 1'b0; wr_en = 1'b0; construir = 1'b0; ready = 1'b0;
        wr_addr = '0; wr_data = '0; fonte = '0; destino = '0;
        tickn(2);
        chk("rst.ocupado", ocupado, 0);
        chk("rst.valid", cv, 0);
        chk("rst.addr", ca, 0);
        chk("rst.ultimo", cu, 0);
        chk("rst.tamanho", ct, 0);
        chk("rst.concluido", concl, 0);
        chk("rst.erro", erro, 0);
        chk("rst.d4", {d4_ocupado, d4_cv, d4_cu, d4_concl, d4_erro, d4_ca, d4_ct}, 0);
        rst_n = 1'b1;
        tick();

        // Path 0 -> 3 -> 5 with ready held high
        write_pred(6'd5, 6'd3);
        write_pred(6'd3, 6'd0);
        ready = 1'b1;
        start(6'd0, 6'd5);
        chk("t1.ocupado", ocupado, 1);
        tickn(5);
        chk("t1.pre_valid", cv, 0);
        chk("t1.tamanho", ct, 3);
        tick(); chk_beat("t1.b0", 1'b1, 6'd0, 1'b0);
        tick(); chk_beat("t1.b1", 1'b1, 6'd3, 1'b0);
        tick(); chk_beat("t1.b2", 1'b1, 6'd5, 1'b1);
        tick();
        chk("t1.valid_end", cv, 0);
        chk("t1.concluido", concl, 1);
        chk("t1.erro", erro, 0);
        chk("t1.ocupado_end", ocupado, 0);
        tick();
        chk("t1.concluido_pulse", concl, 0);

        // Source equals destination
        start(6'd9, 6'd9);
        tick();
        chk("t2.pre_valid", cv, 0);
        chk("t2.tamanho", ct, 1);
        tick(); chk_beat("t2.b0", 1'b1, 6'd9, 1'b1);
        tick();
        chk("t2.valid_end", cv, 0);
        chk("t2.concluido", concl, 1);
        chk("t2.erro", erro, 0);

        // Back-pressure: ready toggles 1,0,0,1,0,0,1
        ready = 1'b0;
        start(6'd0, 6'd5);
        tickn(6);
        chk_beat("t3.b0", 1'b1, 6'd0, 1'b0);
        chk("t3.tamanho", ct, 3);
        for (int i = 0; i < 6; i++) begin
            ready = RDY_SEQ[i];
            tick();
            chk_beat($sformatf("t3.s%0d", i), 1'b1, EXP_A[i], EXP_U[i]);
            chk($sformatf("t3.s%0d.concluido", i), concl, 0);
        end
        ready = 1'b1;
        tick();
        chk("t3.valid_end", cv, 0);
        chk("t3.concluido", concl, 1);

        // Clear coinciding with a write, then an unreachable source
        limpar = 1'b1; wr_en = 1'b1; wr_addr = 6'd7; wr_data = 6'd4;
        tick();
        limpar = 1'b0; wr_en = 1'b0;
        start(6'd0, 6'd7);
        tick();
        chk("t4.e1.erro", erro, 0);
        chk("t4.e1.ocupado", ocupado, 1);
        tickn(2);
        chk("t4.erro", erro, 1);
        chk("t4.concluido", concl, 1);
        chk("t4.ocupado", ocupado, 0);
        chk("t4.valid", cv, 0);
        tick();
        chk("t4.erro_pulse", erro, 0);
        start(6'd0, 6'd5);
        tick();
        chk("t4.cleared.erro", erro, 1);
        chk("t4.cleared.concluido", concl, 1);
        tick();

        // Predecessor loop 1 <-> 2 overflows the 4-deep stack; writes mid-walk are dropped
        write_pred(6'd1, 6'd2);
        write_pred(6'd2, 6'd1);
        start(6'd0, 6'd1);
        tick();
        wr_en = 1'b1; wr_addr = 6'd1; wr_data = 6'd0;
        tick();
        wr_addr = 6'd2;
        tick();
        wr_en = 1'b0;
        tickn(3);
        chk("t5.e6.d4_erro", d4_erro, 0);
        chk("t5.e6.d4_ocupado", d4_ocupado, 1);
        tick();
        chk("t5.d4_erro", d4_erro, 1);
        chk("t5.d4_concluido", d4_concl, 1);
        chk("t5.d4_ocupado", d4_ocupado, 0);
        chk("t5.main_busy", ocupado, 1);
        tickn(120);
        chk("t5.main_erro", erro, 1);
        chk("t5.main_concluido", concl, 1);
        tick();
        start(6'd0, 6'd1);
        tickn(7);
        chk("t5.rerun.d4_erro", d4_erro, 1);
        chk("t5.rerun.d4_valid", d4_cv, 0);
        tickn(120);
        chk("t5.rerun.main_erro", erro, 1);
        tick();

        // Reset in the middle of streaming
        write_pred(6'd5, 6'd3);
        write_pred(6'd3, 6'd0);
        ready = 1'b0;
        start(6'd0, 6'd5);
        tickn(6);
        chk_beat("t6.b0", 1'b1, 6'd0, 1'b0);
        rst_n = 1'b0;
        tick();
        chk("t6.valid", cv, 0);
        chk("t6.ocupado", ocupado, 0);
        chk("t6.tamanho", ct, 0);
        chk("t6.d4_valid", d4_cv, 0);
        rst_n = 1'b1;
        tick();
        ready = 1'b1;
        start(6'd0, 6'd5);
        tick();
        chk("t6.erro", erro, 1);
        chk("t6.concluido", concl, 1);
        chk("t6.valid_after", cv, 0);
        chk("t6.d4_erro", d4_erro, 1);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
